// File: rtl/ex_mc_ctrl_if.sv
// EX-stage <-> multi-cycle sequencer bundle: operands, flush and the HI/LO write-back.
interface ex_mc_ctrl_if;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic [63:0] mul_i;
  logic [63:0] hilo_i;
  logic        annul_i;
  logic        stallreq_o;
  logic        ready_o;
  logic        whilo_o;
  logic [63:0] result_o;

  modport master (
    output start_i, op_i, opdata1_i, opdata2_i, mul_i, hilo_i, annul_i,
    input  stallreq_o, ready_o, whilo_o, result_o
  );

  modport slave (
    input  start_i, op_i, opdata1_i, opdata2_i, mul_i, hilo_i, annul_i,
    output stallreq_o, ready_o, whilo_o, result_o
  );
endinterface

// File: rtl/ex_mc_ctrl.sv
// Multi-cycle EX sequencer: 32-step restoring divider and two-cycle MADD/MSUB accumulate
// into HI/LO, stalling the pipeline until a one-cycle {HI,LO} write is presented.
module ex_mc_ctrl #(
  parameter int DIV_STEPS = 32
) (
  input  logic         clk,
  input  logic         rst,
  ex_mc_ctrl_if.slave  bus
);

  localparam int CNT_W = $clog2(DIV_STEPS) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MAC      = 3'd1,
    DIV_ZERO = 3'd2,
    DIV_ON   = 3'd3,
    DONE     = 3'd4
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [64:0]       work_q;
  logic [31:0]       divisor_q;
  logic              neg_quo_q;
  logic              neg_rem_q;
  logic [63:0]       hilo_q;
  logic [63:0]       mul_q;
  logic              sub_q;
  logic [63:0]       result_q;
  logic              ready_q;

  logic              is_div;
  logic              is_mac;
  logic              signed_div;
  logic [31:0]       dividend_abs;
  logic [31:0]       divisor_abs;
  logic [32:0]       diff;
  logic [64:0]       work_d;
  logic              stall;

  // Applies the DIV sign rules: quotient negative when signs differ, remainder follows dividend.
  function automatic logic [63:0] div_result(input logic [31:0] rem, input logic [31:0] quo,
                                             input logic neg_quo, input logic neg_rem);
    logic [31:0] r;
    logic [31:0] q;
    r = neg_rem ? (~rem + 32'd1) : rem;
    q = neg_quo ? (~quo + 32'd1) : quo;
    return {r, q};
  endfunction

  always_comb begin
    is_div       = (bus.op_i[2:1] == 2'b00);
    is_mac       = (bus.op_i >= 3'd2) && (bus.op_i <= 3'd5);
    signed_div   = (bus.op_i == 3'd0);
    dividend_abs = (signed_div && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    divisor_abs  = (signed_div && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
  end

  // One restoring step: keep the partial remainder only when the subtraction does not borrow.
  always_comb begin
    diff   = work_q[64:32] - {1'b0, divisor_q};
    work_d = diff[32] ? {work_q[63:0], 1'b0} : {diff[31:0], work_q[31:0], 1'b1};
  end

  always_comb begin
    stall = 1'b0;
    case (state_q)
      IDLE:                  stall = bus.start_i && !bus.annul_i && (is_div || is_mac);
      MAC, DIV_ZERO, DIV_ON: stall = !bus.annul_i;
      default:               stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hilo_q    <= '0;
      mul_q     <= '0;
      sub_q     <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            if (is_mac) begin
              hilo_q  <= bus.hilo_i;
              mul_q   <= bus.mul_i;
              sub_q   <= bus.op_i[2];
              state_q <= MAC;
            end else if (is_div) begin
              if (bus.opdata2_i == 32'd0) begin
                state_q <= DIV_ZERO;
              end else begin
                cnt_q     <= '0;
                work_q    <= {32'd0, dividend_abs, 1'b0};
                divisor_q <= divisor_abs;
                neg_quo_q <= signed_div && (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
                neg_rem_q <= signed_div && bus.opdata1_i[31];
                state_q   <= DIV_ON;
              end
            end
          end
        end
        MAC: begin
          if (bus.annul_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= sub_q ? (hilo_q - mul_q) : (hilo_q + mul_q);
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DIV_ZERO: begin
          if (bus.annul_i) begin
            state_q <= IDLE;
          end else begin
            result_q <= 64'd0;
            ready_q  <= 1'b1;
            state_q  <= DONE;
          end
        end
        DIV_ON: begin
          if (bus.annul_i) begin
            state_q <= IDLE;
          end else begin
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_STEP) begin
              result_q <= div_result(work_d[64:33], work_d[31:0], neg_quo_q, neg_rem_q);
              ready_q  <= 1'b1;
              state_q  <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stallreq_o = stall;
  assign bus.ready_o    = ready_q;
  assign bus.whilo_o    = ready_q;
  assign bus.result_o   = result_q;

endmodule

// File: tb/tb_ex_mc_ctrl.sv
// Scoreboard bench for ex_mc_ctrl: directed cases, annul/reset aborts and random op streams.
module tb_ex_mc_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_mc_ctrl_if bus ();

  ex_mc_ctrl #(.DIV_STEPS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [2:0] OP_DIV = 3'd0, OP_DIVU = 3'd1, OP_MADD = 3'd2,
                         OP_MADDU = 3'd3, OP_MSUB = 3'd4, OP_MSUBU = 3'd5;

  typedef struct {
    logic [63:0] res;
    int          cyc;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;
  int          st_from = 0;
  int          st_to = -1;
  bit          mon_en = 1'b0;
  logic [63:0] last_res = 64'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: quotient/remainder from 64-bit integer division, MAC from wrapping 64-bit sums.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] m,
                                        input logic [63:0] h);
    longint sa, sb2, q, r;
    case (op)
      OP_DIV, OP_DIVU: begin
        if (b == 32'd0) return 64'd0;
        if (op == OP_DIV) begin
          sa  = longint'($signed(a));
          sb2 = longint'($signed(b));
        end else begin
          sa  = longint'({32'd0, a});
          sb2 = longint'({32'd0, b});
        end
        q = sa / sb2;
        r = sa % sb2;
        return {r[31:0], q[31:0]};
      end
      OP_MADD, OP_MADDU: return h + m;
      OP_MSUB, OP_MSUBU: return h - m;
      default: return 64'd0;
    endcase
  endfunction

  function automatic int latency(input logic [2:0] op, input logic [31:0] b);
    if (op <= OP_DIVU && b != 32'd0) return 33;
    return 2;
  endfunction

  // Monitor: stall window, whilo/ready agreement and scoreboard pops on every ready.
  always @(negedge clk) begin
    if (mon_en) begin
      check("stallreq", {63'd0, bus.stallreq_o}, {63'd0, (cyc >= st_from && cyc <= st_to)});
      check("whilo_eq_ready", {63'd0, bus.whilo_o}, {63'd0, bus.ready_o});
      if (bus.ready_o) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: got ready=1 with result %h expected no write (cycle %0d)",
                   bus.result_o, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check({e.name, "_result"}, bus.result_o, e.res);
          check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
          last_res = e.res;
        end
      end
    end
  end

  task automatic scramble(input bit keep_op);
    bus.opdata1_i = $urandom;
    bus.opdata2_i = $urandom;
    bus.mul_i     = {$urandom, $urandom};
    bus.hilo_i    = {$urandom, $urandom};
    if (!keep_op) bus.op_i = 3'($urandom_range(0, 7));
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] m, input logic [63:0] h);
    bus.start_i   = 1'b1;
    bus.annul_i   = 1'b0;
    bus.op_i      = op;
    bus.opdata1_i = a;
    bus.opdata2_i = b;
    bus.mul_i     = m;
    bus.hilo_i    = h;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] m, input logic [63:0] h, input string name);
    int t;
    int lat;
    @(posedge clk); #1;
    t = cyc;
    drive(op, a, b, m, h);
    lat = latency(op, b);
    st_from = t;
    if (op > OP_MSUBU) begin
      st_to = t - 1;
    end else begin
      st_to = t + lat - 1;
      sb.push_back('{model(op, a, b, m, h), t + lat, name});
    end
    repeat (lat) begin
      @(posedge clk); #1;
      scramble(op > OP_MSUBU);
    end
    bus.start_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 1'b0; bus.annul_i = 1'b0; bus.op_i = 3'd0;
    bus.opdata1_i = '0; bus.opdata2_i = '0; bus.mul_i = '0; bus.hilo_i = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("reset_result", bus.result_o, 64'd0);
    check("reset_ready", {63'd0, bus.ready_o}, 64'd0);

    run_op(OP_DIV,   32'h00000007, 32'hFFFFFFFE, 64'd0, 64'd0, "div_7_m2");
    run_op(OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 64'd0, 64'd0, "divu_big");
    run_op(OP_DIV,   32'hFFFFFFF9, 32'h00000002, 64'd0, 64'd0, "div_m7_2");
    run_op(OP_DIV,   32'h12345678, 32'h00000000, 64'd0, 64'd0, "div_by_zero");
    run_op(OP_MADD,  32'd0, 32'd0, 64'd1, 64'h00000000_FFFFFFFF, "madd_carry");
    run_op(OP_MSUB,  32'd0, 32'd0, 64'd1, 64'd0, "msub_wrap");
    run_op(OP_DIV,   32'h80000000, 32'hFFFFFFFF, 64'd0, 64'd0, "div_minint");
    run_op(3'd6,     32'd5, 32'd1, 64'd0, 64'd0, "reserved");

    // Annul at T+10 of a DIV: stall drops that cycle, nothing is written.
    begin
      int t;
      @(posedge clk); #1;
      t = cyc;
      drive(OP_DIV, 32'd1000, 32'd7, 64'd0, 64'd0);
      st_from = t; st_to = t + 9;
      repeat (10) begin @(posedge clk); #1; scramble(1'b0); end
      bus.annul_i = 1'b1;
      @(posedge clk); #1;
      bus.annul_i = 1'b0; bus.start_i = 1'b0;
      @(negedge clk);
      check("annul_keeps_result", bus.result_o, last_res);
      repeat (30) @(posedge clk);
    end

    // Reset at T+5 of a DIV: outputs clear from T+6.
    begin
      int t;
      @(posedge clk); #1;
      t = cyc;
      drive(OP_DIV, 32'd99, 32'd4, 64'd0, 64'd0);
      st_from = t; st_to = t + 5;
      repeat (5) @(posedge clk);
      #1 rst = 1'b1; bus.start_i = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_res = 64'd0;
      @(negedge clk);
      check("rst_mid_result", bus.result_o, 64'd0);
      check("rst_mid_ready", {63'd0, bus.ready_o}, 64'd0);
      check("rst_mid_whilo", {63'd0, bus.whilo_o}, 64'd0);
      repeat (40) @(posedge clk);
    end

    run_op(OP_DIVU, 32'd10, 32'd3, 64'd0, 64'd0, "divu_10_3");

    for (int i = 0; i < 30; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 6));
      a  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = ($urandom_range(0, 1) == 0) ? 32'hFFFFFFFF : $urandom;
        default: b = $urandom;
      endcase
      run_op(op, a, b, {$urandom, $urandom}, {$urandom, $urandom}, "rand");
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (4) @(posedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_ready: got %0d pending writes expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mc_ctrl.md
Name: ex_mc_ctrl

Overview:
- Multi-cycle execute sequencer that sits beside the EX stage.
- Owns the operations the single-cycle EX datapath cannot finish in one pass:
  - DIV/DIVU, done as a 32-step shift-subtract divider;
  - MADD/MADDU/MSUB/MSUBU, done as a two-cycle accumulate into HI/LO using the EX multiplier product.
- Raises a stall request to the pipeline controller until its result is ready.
- Presents the final {HI,LO} write with whilo for exactly one cycle.

Parameters:
- DIV_STEPS, 32, number of divider iterations; must equal the operand width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset (`RstEnable = 1'b1).
- start_i  in  1  EX holds a multi-cycle instruction; stays high for as long as that instruction is stalled in EX.
- op_i  in  3  operation select: 0 DIV, 1 DIVU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU; 6–7 reserved.
- opdata1_i  in  32  dividend (rs).
- opdata2_i  in  32  divisor (rt).
- mul_i  in  64  EX multiplier product, already signed or unsigned per op.
- hilo_i  in  64  forwarded current {HI,LO}.
- annul_i  in  1  flush of the instruction in EX.
- stallreq_o  out  1  stall request to the pipeline controller.
- ready_o  out  1  result valid this cycle.
- whilo_o  out  1  HI/LO write enable.
- result_o  out  64  {HI,LO} result.

Behaviour:
- States: IDLE, MAC, DIV_ZERO, DIV_ON, DONE.
- Reset (rst=1 at a clock edge, from any state):
  - state goes to IDLE; counter, dividend register and captured operands are cleared;
  - all outputs are 0 in the following cycle;
  - an operation in flight is abandoned with no write.
- IDLE with start_i=1, annul_i=0 (cycle T):
  - MADD/MADDU/MSUB/MSUBU: capture hilo_i and mul_i, go to MAC.
  - DIV/DIVU with opdata2_i==0: go to DIV_ZERO.
  - DIV/DIVU otherwise: go to DIV_ON, cnt=0.
    - DIV captures |opdata1_i| and |opdata2_i| plus both sign bits.
    - DIVU captures the operands raw.
    - The 65-bit working register is loaded with {32'b0, dividend, 1'b0}.
  - Reserved op: stay in IDLE; no stall, no write.
- MAC (one cycle):
  - MADD/MADDU: acc = hilo + mul. MSUB/MSUBU: acc = hilo − mul.
  - All arithmetic is modulo 2^64.
  - Go to DONE.
- DIV_ZERO (one cycle): result = 64'h0. Go to DONE.
- DIV_ON: one restoring step per cycle.
  - Compute diff = work[64:32] − {1'b0, divisor}.
  - If diff is negative: work = work << 1.
  - Otherwise: work = {diff[31:0], work[31:0], 1'b1}.
  - cnt increments each step. The step with cnt == DIV_STEPS−1 goes to DONE.
  - Sign fix for DIV:
    - quotient is negated when the two sign bits differ;
    - remainder takes the sign of the dividend.
  - Result layout: HI = remainder = work[64:33]; LO = quotient = work[31:0].
- DONE (exactly one cycle): ready_o=1, whilo_o=1, result_o valid, stallreq_o=0. Unconditionally go to IDLE.
- result_o holds its value until the next DONE. ready_o and whilo_o are 0 outside DONE.
- Latency, with the start cycle as T:
  - MAC and DIV_ZERO reach DONE in T+2.
  - DIV and DIVU reach DONE in T+1+DIV_STEPS, i.e. T+33.
- stallreq_o is combinational: 1 when (state==IDLE & start_i & valid op & !annul_i) or state ∈ {MAC, DIV_ZERO, DIV_ON}.
- annul_i=1 in any non-IDLE, non-DONE state:
  - next state is IDLE;
  - stallreq_o is 0 in that cycle;
  - no ready/whilo is produced;
  - result_o is unchanged.
- annul_i in DONE has no effect; the write still occurs.
- Back-to-back operations: the cycle after DONE is IDLE, and a new start_i there begins a new operation with no bubble inside the block.
- Operands are sampled only on the IDLE→busy transition. Input changes during busy states are ignored.

Test Plan:
- DIV 7 / −2 (0x00000007, 0xFFFFFFFE) → ready in T+33; result_o = {0x00000001, 0xFFFFFFFD}; stallreq_o high T..T+32, low T+33.
- DIVU 0xFFFFFFFF / 0x00000010 → {0x0000000F, 0x0FFFFFFF} at T+33.
- DIV −7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}.
- DIV x / 0 → result 64'h0 with ready and whilo at T+2.
- MADD with hilo_i = 0x00000000_FFFFFFFF and mul_i = 1 → 0x00000001_00000000 at T+2.
- MSUB with hilo_i = 0 and mul_i = 1 → 0xFFFFFFFF_FFFFFFFF.
- annul_i at T+10 of a DIV → IDLE at T+11; no ready/whilo ever; stallreq_o drops in T+10; result_o keeps its previous value.
- Then rst at T+5 of a second DIV → all outputs 0 from T+6; a new DIVU 10/3 started afterwards returns {1, 3}.
